// File: rtl/kamacore_pkg.sv
// Shared kamacore constants and types for the dual-port word memory.
package kamacore_pkg;

  localparam int unsigned CPU_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned MEM_BYTES  = CPU_WIDTH / 8;
  localparam int unsigned MEM_OFFS   = $clog2(MEM_BYTES);

  typedef enum logic {MEM_CLEAR, MEM_READY} mem_state_t;

  // Bytes with be set come from upd, the rest from base.
  function automatic logic [CPU_WIDTH-1:0] be_merge(input logic [CPU_WIDTH-1:0] base,
                                                   input logic [CPU_WIDTH-1:0] upd,
                                                   input logic [MEM_BYTES-1:0] be);
    logic [CPU_WIDTH-1:0] res;
    res = base;
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      if (be[i]) res[i*8 +: 8] = upd[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/kamacore_dual_mem_if.sv
// Fetch and load/store request/response bundle for kamacore_dual_mem.
interface kamacore_dual_mem_if
  import kamacore_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = ADDR_WIDTH
);

  logic                      ready;

  logic                      if_req;
  logic [MEM_ADDR_WIDTH-1:0] if_addr;
  logic                      if_valid;
  logic [CPU_WIDTH-1:0]      if_rdata;
  logic                      if_err;

  logic                      d_req;
  logic                      d_we;
  logic [MEM_BYTES-1:0]      d_be;
  logic [MEM_ADDR_WIDTH-1:0] d_addr;
  logic [CPU_WIDTH-1:0]      d_wdata;
  logic                      d_valid;
  logic [CPU_WIDTH-1:0]      d_rdata;
  logic                      d_err;

  modport master (
    input  ready, if_valid, if_rdata, if_err, d_valid, d_rdata, d_err,
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata
  );

  modport slave (
    output ready, if_valid, if_rdata, if_err, d_valid, d_rdata, d_err,
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata
  );

endinterface

// File: rtl/kamacore_mem_bank.sv
// Word RAM: one byte-enable write port, two registered read-first read ports, array not reset.
module kamacore_mem_bank #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32,
  parameter int unsigned IdxW  = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [Width/8-1:0] be,
  input  logic [IdxW-1:0]    waddr,
  input  logic [Width-1:0]   wdata,
  input  logic [IdxW-1:0]    raddr_a,
  output logic [Width-1:0]   rdata_a,
  input  logic [IdxW-1:0]    raddr_b,
  output logic [Width-1:0]   rdata_b
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(Width / 8); i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/kamacore_dual_mem.sv
// Two-port kamacore memory with post-reset clear, range/alignment checks and 1-cycle responses.
// Optional fetch/write collision forwarding is enabled by defining KAMACORE_MEM_FWD_EN.
module kamacore_dual_mem
  import kamacore_pkg::*;
#(
  parameter int unsigned          MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int unsigned          RAM_SIZE       = 1024,
  parameter logic [CPU_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic               clk,
  input logic               rst,
  kamacore_dual_mem_if.slave bus
);

  localparam int unsigned IdxW   = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam int unsigned WordAW = MEM_ADDR_WIDTH - MEM_OFFS;

  mem_state_t      state_q, state_d;
  logic [IdxW-1:0] clear_ptr_q, clear_ptr_d;
  logic            ready;

  assign ready     = (state_q == MEM_READY);
  assign bus.ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    unique case (state_q)
      MEM_CLEAR: begin
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == IdxW'(RAM_SIZE - 1)) state_d = MEM_READY;
      end
      MEM_READY: ;
    endcase
  end

  logic [WordAW-1:0] if_word, d_word;
  logic              if_bad, d_bad;
  logic              if_acc, d_acc, d_wr_ok;

  assign if_word = bus.if_addr[MEM_ADDR_WIDTH-1:MEM_OFFS];
  assign d_word  = bus.d_addr[MEM_ADDR_WIDTH-1:MEM_OFFS];
  assign if_bad  = (|bus.if_addr[MEM_OFFS-1:0]) || (64'(if_word) >= 64'(RAM_SIZE));
  assign d_bad   = (|bus.d_addr[MEM_OFFS-1:0]) || (64'(d_word) >= 64'(RAM_SIZE));

  assign if_acc  = bus.if_req & ready & ~rst;
  assign d_acc   = bus.d_req & ready & ~rst;
  assign d_wr_ok = d_acc & bus.d_we & ~d_bad;

  logic                 bank_we;
  logic [MEM_BYTES-1:0] bank_be;
  logic [IdxW-1:0]      bank_waddr;
  logic [CPU_WIDTH-1:0] bank_wdata;
  logic [CPU_WIDTH-1:0] bank_rdata_a, bank_rdata_b;

  // The clear sequence owns the write port until the memory is ready.
  always_comb begin
    bank_we    = 1'b0;
    bank_be    = '1;
    bank_waddr = clear_ptr_q;
    bank_wdata = CLEAR_VALUE;
    if (state_q == MEM_CLEAR) begin
      bank_we = ~rst;
    end else begin
      bank_we    = d_wr_ok;
      bank_be    = bus.d_be;
      bank_waddr = d_word[IdxW-1:0];
      bank_wdata = bus.d_wdata;
    end
  end

  kamacore_mem_bank #(
    .Depth (RAM_SIZE),
    .Width (CPU_WIDTH),
    .IdxW  (IdxW)
  ) u_bank (
    .clk     (clk),
    .we      (bank_we),
    .be      (bank_be),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .raddr_a (if_word[IdxW-1:0]),
    .rdata_a (bank_rdata_a),
    .raddr_b (d_word[IdxW-1:0]),
    .rdata_b (bank_rdata_b)
  );

  logic if_valid_q, if_err_q;
  logic d_valid_q, d_err_q, d_rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
      d_rd_q     <= 1'b0;
    end else begin
      if_valid_q <= if_acc;
      if_err_q   <= if_acc & if_bad;
      d_valid_q  <= d_acc;
      d_err_q    <= d_acc & d_bad;
      d_rd_q     <= d_acc & ~bus.d_we & ~d_bad;
    end
  end

  logic [CPU_WIDTH-1:0] if_data;

`ifdef KAMACORE_MEM_FWD_EN
  logic                 fwd_hit_q;
  logic [MEM_BYTES-1:0] fwd_be_q;
  logic [CPU_WIDTH-1:0] fwd_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_q   <= 1'b0;
      fwd_be_q    <= '0;
      fwd_wdata_q <= '0;
    end else begin
      fwd_hit_q   <= if_acc & ~if_bad & d_wr_ok & (if_word == d_word);
      fwd_be_q    <= bus.d_be;
      fwd_wdata_q <= bus.d_wdata;
    end
  end

  assign if_data = fwd_hit_q ? be_merge(bank_rdata_a, fwd_wdata_q, fwd_be_q) : bank_rdata_a;
`else
  assign if_data = bank_rdata_a;
`endif

  assign bus.if_valid = if_valid_q;
  assign bus.if_err   = if_err_q;
  assign bus.if_rdata = (if_valid_q & ~if_err_q) ? if_data : '0;
  assign bus.d_valid  = d_valid_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_rdata  = d_rd_q ? bank_rdata_b : '0;

endmodule
